// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder: FSM state encoding and
// the counter-width rule.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_DONE   = 2'd2,
        S_UNUSED = 2'd3
    } state_e;

    localparam int DEFAULT_WIDTH = 8;

    // Bit counter must reach WIDTH-1; guard the degenerate $clog2 result.
    function automatic int cnt_width(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/serial_adder_if.sv
// Request/result bundle between a requester and the bit-serial adder.
interface serial_adder_if #(
    parameter int WIDTH = 8
);

    // Start is a request that the adder accepts only while idle, with no
    // back-pressure signal: a Start seen while Busy or Done is dropped. Done is
    // a one-cycle pulse. Result/CarryOut are valid with Done and stay unchanged
    // until the next accepted Start completes.
    logic             Start;
    logic [WIDTH-1:0] OpA;
    logic [WIDTH-1:0] OpB;
    logic             Busy;
    logic             Done;
    logic [WIDTH-1:0] Result;
    logic             CarryOut;

    modport master (
        output Start, OpA, OpB,
        input  Busy, Done, Result, CarryOut
    );

    modport slave (
        input  Start, OpA, OpB,
        output Busy, Done, Result, CarryOut
    );

endinterface

// File: rtl/full_adder_cell.sv
// Full adder built from two half adders; the only arithmetic in the serial adder.
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic s0;
    logic c0;
    logic c1;

    half_adder u_ha0 (
        .a (a),
        .b (b),
        .s (s0),
        .c (c0)
    );

    half_adder u_ha1 (
        .a (s0),
        .b (cin),
        .s (s),
        .c (c1)
    );

    // Both half-adder carries can never be high together, so OR is exact.
    assign cout = c0 | c1;

endmodule

// File: rtl/half_adder.sv
// Single-bit half adder: the basic cell upstream of the serial adder.
module half_adder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);

    assign s = a ^ b;
    assign c = a & b;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: captures two operands on Start, adds them LSB-first one
// bit per clock, and presents Result/CarryOut with a one-cycle Done pulse.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic            Clk,
    input  logic            Rst,
    serial_adder_if.slave   bus,
    output state_e          dbg_state
);

    localparam int                CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0]     LAST = CW'(WIDTH - 1);

    state_e           state_q,  state_d;
    logic [WIDTH-1:0] opa_q,    opa_d;
    logic [WIDTH-1:0] opb_q,    opb_d;
    logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             carry_q,  carry_d;
    logic             cout_q,   cout_d;
    logic [CW-1:0]    cnt_q,    cnt_d;

    logic             fa_s;
    logic             fa_cout;

    full_adder_cell u_fa (
        .a    (opa_q[0]),
        .b    (opb_q[0]),
        .cin  (carry_q),
        .s    (fa_s),
        .cout (fa_cout)
    );

    always_comb begin
        state_d  = state_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        sum_sh_d = sum_sh_q;
        result_d = result_q;
        carry_d  = carry_q;
        cout_d   = cout_q;
        cnt_d    = cnt_q;

        case (state_q)
            S_IDLE: begin
                if (bus.Start) begin
                    state_d = S_RUN;
                    opa_d   = bus.OpA;
                    opb_d   = bus.OpB;
                    carry_d = 1'b0;
                    cnt_d   = '0;
                end
            end
            S_RUN: begin
                // Sum bits enter at the MSB so WIDTH shifts leave bit 0 at the LSB.
                sum_sh_d = {fa_s, sum_sh_q[WIDTH-1:1]};
                carry_d  = fa_cout;
                opa_d    = opa_q >> 1;
                opb_d    = opb_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d  = S_DONE;
                    result_d = {fa_s, sum_sh_q[WIDTH-1:1]};
                    cout_d   = fa_cout;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q  <= S_IDLE;
            opa_q    <= '0;
            opb_q    <= '0;
            sum_sh_q <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            cout_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            sum_sh_q <= sum_sh_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            cout_q   <= cout_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.Busy     = (state_q == S_RUN);
    assign bus.Done     = (state_q == S_DONE);
    assign bus.Result   = result_q;
    assign bus.CarryOut = cout_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed checks of the 8-bit serial adder: reset, latency, wrap-around,
// ignored Start, mid-run reset and back-to-back operation.
module tb_serial_adder;
    import serial_adder_pkg::*;

    localparam int W = 8;

    logic   clk = 1'b0;
    logic   rst;
    state_e dbg_state;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [W:0] exp_q[$];

    serial_adder_if #(.WIDTH(W)) bus ();

    serial_adder #(.WIDTH(W)) dut (
        .Clk       (clk),
        .Rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
        bus.Start = 1'b1;
        bus.OpA   = a;
        bus.OpB   = b;
        tick();
        bus.Start = 1'b0;
    endtask

    // Watches n cycles (index 0 = just after the capture edge), no checking.
    task automatic observe(input int n, output int busy_n, output int done_n,
                           output int done_at, output logic [W:0] res_at_done);
        busy_n      = 0;
        done_n      = 0;
        done_at     = -1;
        res_at_done = '0;
        for (int i = 0; i < n; i++) begin
            if (bus.Busy) busy_n++;
            if (bus.Done) begin
                done_n++;
                done_at     = i;
                res_at_done = {bus.CarryOut, bus.Result};
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        bus.Start = 1'b0;
        bus.OpA   = '0;
        bus.OpB   = '0;
        tick();
        tick();
        tests_run++;
        if (bus.Busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_busy: got %b expected 0", bus.Busy);
        end
        tests_run++;
        if (bus.Done !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_done: got %b expected 0", bus.Done);
        end
        tests_run++;
        if (bus.Result !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_result: got %h expected 00", bus.Result);
        end
        tests_run++;
        if (bus.CarryOut !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_carry: got %b expected 0", bus.CarryOut);
        end
        tests_run++;
        if (dbg_state !== S_IDLE) begin
            tests_failed++;
            $display("FAIL reset_state: got %0d expected %0d", dbg_state, S_IDLE);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        logic       exp_busy;
        logic       exp_done;
        logic [W:0] exp_res;
        start_op(8'h5A, 8'hA5);
        // 0x5A + 0xA5 = 0x0FF; Busy for 8 cycles, Done at the 9th.
        for (int i = 0; i < 12; i++) begin
            exp_busy = (i < 8);
            exp_done = (i == 8);
            exp_res  = (i < 8) ? 9'h000 : 9'h0FF;
            tests_run++;
            if (bus.Busy !== exp_busy) begin
                tests_failed++;
                $display("FAIL basic_busy[%0d]: got %b expected %b", i, bus.Busy, exp_busy);
            end
            tests_run++;
            if (bus.Done !== exp_done) begin
                tests_failed++;
                $display("FAIL basic_done[%0d]: got %b expected %b", i, bus.Done, exp_done);
            end
            tests_run++;
            if ({bus.CarryOut, bus.Result} !== exp_res) begin
                tests_failed++;
                $display("FAIL basic_result[%0d]: got %h expected %h", i, {bus.CarryOut, bus.Result}, exp_res);
            end
            tick();
        end
    endtask

    task automatic test_wrap();
        logic [W-1:0] a_tab [4] = '{8'hFF, 8'h80, 8'h7F, 8'hFF};
        logic [W-1:0] b_tab [4] = '{8'h01, 8'h80, 8'h01, 8'hFF};
        logic [W:0]   r_tab [4] = '{9'h100, 9'h100, 9'h080, 9'h1FE};
        int           busy_n, done_n, done_at;
        logic [W:0]   res;
        for (int t = 0; t < 4; t++) begin
            start_op(a_tab[t], b_tab[t]);
            observe(12, busy_n, done_n, done_at, res);
            tests_run++;
            if (done_n !== 1 || done_at !== 8) begin
                tests_failed++;
                $display("FAIL wrap_done[%0d]: got %0d pulses at %0d expected 1 at 8", t, done_n, done_at);
            end
            tests_run++;
            if (res !== r_tab[t]) begin
                tests_failed++;
                $display("FAIL wrap_result[%0d]: got %h expected %h", t, res, r_tab[t]);
            end
        end
    endtask

    task automatic test_start_ignored();
        int         busy_n, done_n, done_at;
        logic [W:0] res;
        start_op(8'h12, 8'h34);
        tick();
        tick();
        tick();
        bus.Start = 1'b1;
        bus.OpA   = 8'hFF;
        bus.OpB   = 8'hFF;
        tick();
        tick();
        bus.Start = 1'b0;
        observe(9, busy_n, done_n, done_at, res);
        tests_run++;
        if (done_n !== 1) begin
            tests_failed++;
            $display("FAIL ignored_done_count: got %0d expected 1", done_n);
        end
        tests_run++;
        if (res !== 9'h046) begin
            tests_failed++;
            $display("FAIL ignored_result: got %h expected 046", res);
        end
        tests_run++;
        if (bus.Busy !== 1'b0 || dbg_state !== S_IDLE) begin
            tests_failed++;
            $display("FAIL ignored_idle: got busy=%b state=%0d expected busy=0 state=0", bus.Busy, dbg_state);
        end
    endtask

    task automatic test_reset_mid_run();
        int         busy_n, done_n, done_at;
        logic [W:0] res;
        start_op(8'h55, 8'h66);
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests_run++;
        if ({bus.Busy, bus.Done, bus.CarryOut, bus.Result} !== 11'h000) begin
            tests_failed++;
            $display("FAIL midrst_outputs: got busy=%b done=%b res=%h expected all 0",
                     bus.Busy, bus.Done, {bus.CarryOut, bus.Result});
        end
        tests_run++;
        if (dbg_state !== S_IDLE) begin
            tests_failed++;
            $display("FAIL midrst_state: got %0d expected 0", dbg_state);
        end
        observe(10, busy_n, done_n, done_at, res);
        tests_run++;
        if (done_n !== 0 || busy_n !== 0) begin
            tests_failed++;
            $display("FAIL midrst_quiet: got busy_n=%0d done_n=%0d expected 0 0", busy_n, done_n);
        end
        rst       = 1'b1;
        bus.Start = 1'b1;
        bus.OpA   = 8'h01;
        bus.OpB   = 8'h01;
        tick();
        rst       = 1'b0;
        bus.Start = 1'b0;
        tests_run++;
        if (bus.Busy !== 1'b0 || dbg_state !== S_IDLE) begin
            tests_failed++;
            $display("FAIL rst_beats_start: got busy=%b state=%0d expected busy=0 state=0", bus.Busy, dbg_state);
        end
        start_op(8'h03, 8'h04);
        observe(12, busy_n, done_n, done_at, res);
        tests_run++;
        if (done_n !== 1 || res !== 9'h007) begin
            tests_failed++;
            $display("FAIL midrst_recover: got %0d pulses res=%h expected 1 pulse res=007", done_n, res);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] a [3];
        logic [W-1:0] b [3];
        logic [W:0]   got;
        logic [W:0]   exp;
        int           done_n = 0;
        for (int j = 0; j < 3; j++) begin
            a[j] = W'($urandom_range(0, 255));
            b[j] = W'($urandom_range(0, 255));
        end
        bus.Start = 1'b1;
        bus.OpA   = a[0];
        bus.OpB   = b[0];
        tick();
        exp_q.push_back({1'b0, a[0]} + {1'b0, b[0]});
        bus.OpA = a[1];
        bus.OpB = b[1];
        for (int i = 0; i < 30; i++) begin
            if (bus.Done) begin
                done_n++;
                tests_run++;
                if (i % 10 != 8) begin
                    tests_failed++;
                    $display("FAIL b2b_spacing: got Done at cycle %0d expected cycle 8 mod 10", i);
                end
                got = {bus.CarryOut, bus.Result};
                tests_run++;
                if (exp_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL b2b_extra_done: got result %h expected no Done", got);
                end else begin
                    exp = exp_q.pop_front();
                    if (got !== exp) begin
                        tests_failed++;
                        $display("FAIL b2b_result: got %h expected %h", got, exp);
                    end
                end
            end
            if (i == 10) begin
                exp_q.push_back({1'b0, a[1]} + {1'b0, b[1]});
                bus.OpA = a[2];
                bus.OpB = b[2];
            end
            if (i == 20) begin
                exp_q.push_back({1'b0, a[2]} + {1'b0, b[2]});
                bus.Start = 1'b0;
            end
            tick();
        end
        tests_run++;
        if (done_n !== 3 || exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL b2b_count: got %0d Done pulses, %0d outstanding expected 3 and 0",
                     done_n, exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_start_ignored();
        test_reset_mid_run();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
